// File: rtl/motor_axis_mmio_if.sv
// rtl/motor_axis_mmio_if.sv - APB-style register bus between the fabric and motor_axis_mmio
//
// Signals:
//   psel, penable, pwrite, paddr, pwdata : driven by the fabric (master)
//   prdata, ready (pready), error (pslverr) : driven by the register block (slave)
interface motor_axis_mmio_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              ready;
  logic              error;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, ready, error
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, ready, error
  );
endinterface

// File: rtl/motor_axis_mmio.sv
// rtl/motor_axis_mmio.sv - two-axis motor command/status register block with done interrupt
//
// Ports:
//   clk            : system clock, rising edge
//   reset          : asynchronous active-low reset
//   apb            : register bus (slave modport), zero wait states
//   x/y_counter_in : driver remaining-step count
//   x/y_dir_in     : driver current direction
//   x/y_counter_out: load command, nonzero for exactly one cycle
//   x/y_dir_out    : commanded direction, held until the next command
//   fabint         : registered level interrupt, x_flag | y_flag
//
// Optional build macro MOTOR_MMIO_ERR_EN: flags misaligned / out-of-window
// accesses and writes to STATUS with error, suppressing their effect.
//
// Register map (paddr[3:2]):
//   0 X_CMD   W: {dir, count[30:0]}  R: {x_dir_in, x_counter_in[30:0]}
//   1 Y_CMD   same for Y
//   2 STATUS  R: {y_zero, x_zero, y_flag, x_flag}
//   3 IRQ_CLR W1C: bit0 x_flag, bit1 y_flag; reads 0
module motor_axis_mmio #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  motor_axis_mmio_if.slave  apb,
  input  logic [DATA_W-1:0] x_counter_in,
  input  logic              x_dir_in,
  input  logic [DATA_W-1:0] y_counter_in,
  input  logic              y_dir_in,
  output logic [DATA_W-1:0] x_counter_out,
  output logic              x_dir_out,
  output logic [DATA_W-1:0] y_counter_out,
  output logic              y_dir_out,
  output logic              fabint
);

  logic              access;
  logic              err;
  logic              wr_ok;
  logic              rd_ok;
  logic [1:0]        sel;
  logic [DATA_W-1:0] cmd_count;
  logic              cmd_dir;
  logic              x_cmd_wr, y_cmd_wr, clr_wr;
  logic              x_zero, y_zero;
  logic              last_x_zero, last_y_zero;
  logic              x_done, y_done;
  logic              x_set, y_set, x_clr, y_clr;
  logic              x_flag, y_flag;

  assign access = apb.psel & apb.penable;
  assign sel    = apb.paddr[3:2];

`ifdef MOTOR_MMIO_ERR_EN
  logic bad_addr;
  assign bad_addr = (apb.paddr[ADDR_W-1:4] != '0) || (apb.paddr[1:0] != 2'b00);
  assign err      = access & (bad_addr | (apb.pwrite & (sel == 2'd2)));
`else
  // Only paddr[3:2] is decoded; the remaining bits alias onto the map.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{apb.paddr[ADDR_W-1:4], apb.paddr[1:0]};
  assign err              = 1'b0;
`endif

  assign apb.ready = access;
  assign apb.error = err;
  assign wr_ok     = access &  apb.pwrite & ~err;
  assign rd_ok     = access & ~apb.pwrite & ~err;

  assign cmd_count = {1'b0, apb.pwdata[DATA_W-2:0]};
  assign cmd_dir   = apb.pwdata[DATA_W-1];
  assign x_cmd_wr  = wr_ok & (sel == 2'd0);
  assign y_cmd_wr  = wr_ok & (sel == 2'd1);
  assign clr_wr    = wr_ok & (sel == 2'd3);

  // Done is the 1->0 edge of remaining count; last_*_zero resets to 1 so an
  // idle or mid-motion reset never produces a spurious done.
  assign x_zero = (x_counter_in == '0);
  assign y_zero = (y_counter_in == '0);
  assign x_done = x_zero & ~last_x_zero;
  assign y_done = y_zero & ~last_y_zero;

  // A zero-count command never moves the axis, so it completes immediately.
  // Any command write acknowledges both flags; a coincident set wins.
  assign x_set = x_done | (x_cmd_wr & (cmd_count == '0));
  assign y_set = y_done | (y_cmd_wr & (cmd_count == '0));
  assign x_clr = x_cmd_wr | y_cmd_wr | (clr_wr & apb.pwdata[0]);
  assign y_clr = x_cmd_wr | y_cmd_wr | (clr_wr & apb.pwdata[1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_counter_out <= '0;
      y_counter_out <= '0;
      x_dir_out     <= 1'b0;
      y_dir_out     <= 1'b0;
      last_x_zero   <= 1'b1;
      last_y_zero   <= 1'b1;
      x_flag        <= 1'b0;
      y_flag        <= 1'b0;
      fabint        <= 1'b0;
    end else begin
      x_counter_out <= x_cmd_wr ? cmd_count : '0;
      y_counter_out <= y_cmd_wr ? cmd_count : '0;
      if (x_cmd_wr) x_dir_out <= cmd_dir;
      if (y_cmd_wr) y_dir_out <= cmd_dir;
      last_x_zero <= x_zero;
      last_y_zero <= y_zero;
      if (x_set)      x_flag <= 1'b1;
      else if (x_clr) x_flag <= 1'b0;
      if (y_set)      y_flag <= 1'b1;
      else if (y_clr) y_flag <= 1'b0;
      fabint <= x_flag | y_flag;
    end
  end

  always_comb begin
    apb.prdata = '0;
    if (rd_ok) begin
      case (sel)
        2'd0:    apb.prdata = {x_dir_in, x_counter_in[DATA_W-2:0]};
        2'd1:    apb.prdata = {y_dir_in, y_counter_in[DATA_W-2:0]};
        2'd2:    apb.prdata[3:0] = {y_zero, x_zero, y_flag, x_flag};
        default: apb.prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_axis_mmio.sv
// tb/tb_motor_axis_mmio.sv - self-checking bench for motor_axis_mmio
module tb_motor_axis_mmio;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] x_counter_in, y_counter_in, x_counter_out, y_counter_out;
  logic        x_dir_in, y_dir_in, x_dir_out, y_dir_out, fabint;

  motor_axis_mmio_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  motor_axis_mmio #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .apb           (bus.slave),
    .x_counter_in  (x_counter_in),
    .x_dir_in      (x_dir_in),
    .y_counter_in  (y_counter_in),
    .y_dir_in      (y_dir_in),
    .x_counter_out (x_counter_out),
    .x_dir_out     (x_dir_out),
    .y_counter_out (y_counter_out),
    .y_dir_out     (y_dir_out),
    .fabint        (fabint)
  );

  // Driver models: load on a nonzero command, then count down one per cycle.
  logic [31:0] x_cnt = '0, y_cnt = '0, y_man = '0;
  logic        x_dm = 1'b0, y_dm = 1'b0, man_en = 1'b0;

  always @(posedge clk) begin
    if (x_counter_out != 0) begin x_cnt <= x_counter_out; x_dm <= x_dir_out; end
    else if (x_cnt != 0) x_cnt <= x_cnt - 1;
    if (y_counter_out != 0) begin y_cnt <= y_counter_out; y_dm <= y_dir_out; end
    else if (y_cnt != 0) y_cnt <= y_cnt - 1;
  end

  assign x_counter_in = x_cnt;
  assign x_dir_in     = x_dm;
  assign y_counter_in = man_en ? y_man : y_cnt;
  assign y_dir_in     = y_dm;

  int checks = 0;
  int failures = 0;

  logic [31:0] x_exp_q[$];
  logic [31:0] y_exp_q[$];
  logic [31:0] rd_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Load-pulse scoreboard: every nonzero pulse must match a queued command.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (x_counter_out != 0) begin
        if (x_exp_q.size() == 0) chk("x_load_unexpected", x_counter_out, 32'd0);
        else chk("x_load", x_counter_out, x_exp_q.pop_front());
      end
      if (y_counter_out != 0) begin
        if (y_exp_q.size() == 0) chk("y_load_unexpected", y_counter_out, 32'd0);
        else chk("y_load", y_counter_out, y_exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the access-ending edge.
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wd;
    @(negedge clk);
    bus.penable = 1'b1;
    #1;
    chk("ready", {31'b0, bus.ready}, 32'd1);
    rd = bus.prdata;
    er = bus.error;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] r; logic e;
    apb(1'b1, addr, wd, r, e);
    chk("wr_error", {31'b0, e}, 32'd0);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r; logic e;
    rd_q.push_back(exp);
    apb(1'b0, addr, 32'd0, r, e);
    chk("rd_error", {31'b0, e}, 32'd0);
    chk(nm, r, rd_q.pop_front());
  endtask

  // Issue a nonzero command and read the register back while the driver runs.
  task automatic cmd(input bit axis, input logic [31:0] wd, input logic [31:0] cnt, input bit dir);
    logic f0;
    f0 = fabint;
    if (axis) y_exp_q.push_back(cnt); else x_exp_q.push_back(cnt);
    wr(axis ? 32'h4 : 32'h0, wd);
    chk("fabint_after_cmd", {31'b0, fabint}, {31'b0, f0});
    chk("dir_out", {31'b0, axis ? y_dir_out : x_dir_out}, {31'b0, dir});
    rd_chk("cmd_readback", axis ? 32'h4 : 32'h0, {dir, cnt[30:0]});
    chk("fabint_acked", {31'b0, fabint}, 32'd0);
  endtask

  task automatic wait_done(input bit axis, input logic [31:0] exp_status);
    int i;
    for (i = 0; i < 200; i++) begin
      if ((axis ? y_counter_in : x_counter_in) == 0) break;
      @(negedge clk);
    end
    chk("done_in_budget", {31'b0, (i < 200)}, 32'd1);
    chk("fabint_at_zero", {31'b0, fabint}, 32'd0);
    @(negedge clk);
    chk("fabint_flag_cycle", {31'b0, fabint}, 32'd0);
    @(negedge clk);
    chk("fabint_rise", {31'b0, fabint}, 32'd1);
    rd_chk("status_done", 32'h8, exp_status);
  endtask

  task automatic clr(input logic [31:0] mask);
    wr(32'hC, mask);
    @(negedge clk);
    chk("fabint_cleared", {31'b0, fabint}, 32'd0);
  endtask

  typedef struct {
    bit          axis;
    logic [31:0] wdata;
    logic [31:0] cnt;
    bit          dir;
  } cmd_vec_t;

  cmd_vec_t vecs[5];

  initial begin
    vecs[0] = '{axis: 1'b1, wdata: 32'h0000_0005, cnt: 32'd5, dir: 1'b0};
    vecs[1] = '{axis: 1'b0, wdata: 32'h8000_0003, cnt: 32'd3, dir: 1'b1};
    vecs[2] = '{axis: 1'b0, wdata: 32'h0000_0007, cnt: 32'd7, dir: 1'b0};
    vecs[3] = '{axis: 1'b1, wdata: 32'h8000_0002, cnt: 32'd2, dir: 1'b1};
    vecs[4] = '{axis: 1'b1, wdata: 32'h0000_0001, cnt: 32'd1, dir: 1'b0};

    rst_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;

    // Reset state
    @(negedge clk);
    chk("rst_outputs", {x_counter_out | y_counter_out}, 32'd0);
    chk("rst_dirs_fabint", {29'b0, x_dir_out, y_dir_out, fabint}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_prdata", bus.prdata, 32'd0);
    chk("idle_ready_error", {30'b0, bus.ready, bus.error}, 32'd0);
    @(negedge clk);
    rd_chk("status_reset", 32'h8, 32'h0000_000C);
    rd_chk("irqclr_reads_zero", 32'hC, 32'd0);

    // Table: command, mid-motion readback, done interrupt timing, W1C clear
    for (int v = 0; v < 5; v++) begin
      cmd(vecs[v].axis, vecs[v].wdata, vecs[v].cnt, vecs[v].dir);
      wait_done(vecs[v].axis, vecs[v].axis ? 32'h0000_000E : 32'h0000_000D);
      clr(vecs[v].axis ? 32'h2 : 32'h1);
    end

    // A new command acknowledges a pending interrupt
    cmd(1'b1, 32'd2, 32'd2, 1'b0);
    wait_done(1'b1, 32'h0000_000E);
    cmd(1'b0, 32'd5, 32'd5, 1'b0);
    wait_done(1'b0, 32'h0000_000D);
    clr(32'h1);

    // Zero-count command: no load pulse, flag set directly (set beats clear)
    wr(32'h0, 32'h0);
    chk("zero_cmd_fabint_n1", {31'b0, fabint}, 32'd0);
    chk("zero_cmd_dir", {31'b0, x_dir_out}, 32'd0);
    @(negedge clk);
    chk("zero_cmd_fabint_n2", {31'b0, fabint}, 32'd1);
    rd_chk("zero_cmd_status", 32'h8, 32'h0000_000D);
    clr(32'h1);

    // Reset mid-motion clears flags and outputs without a spurious done
    wr(32'h4, 32'h8000_0000);
    chk("y_dir_set", {31'b0, y_dir_out}, 32'd1);
    man_en = 1'b1; y_man = 32'd2;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_outputs", {x_counter_out | y_counter_out}, 32'd0);
    chk("midrst_dirs_fabint", {29'b0, x_dir_out, y_dir_out, fabint}, 32'd0);
    @(negedge clk);
    chk("midrst_no_spurious1", {31'b0, fabint}, 32'd0);
    @(negedge clk);
    chk("midrst_no_spurious2", {31'b0, fabint}, 32'd0);
    y_man = 32'd0;
    @(negedge clk);
    chk("midrst_flag_cycle", {31'b0, fabint}, 32'd0);
    @(negedge clk);
    chk("midrst_fabint_rise", {31'b0, fabint}, 32'd1);
    rd_chk("midrst_status", 32'h8, 32'h0000_000E);
    clr(32'h2);
    man_en = 1'b0;

    begin
      logic [31:0] r; logic e;
`ifdef MOTOR_MMIO_ERR_EN
      apb(1'b0, 32'h10, 32'd0, r, e);
      chk("err_oob_read_error", {31'b0, e}, 32'd1);
      chk("err_oob_read_data", r, 32'd0);
      apb(1'b1, 32'h8, 32'h3, r, e);
      chk("err_status_write", {31'b0, e}, 32'd1);
      apb(1'b1, 32'h10, 32'h9, r, e);
      chk("err_oob_write", {31'b0, e}, 32'd1);
      @(negedge clk);
      chk("err_write_ignored_fabint", {31'b0, fabint}, 32'd0);
`else
      apb(1'b0, 32'h10, 32'd0, r, e);
      chk("alias_read_error", {31'b0, e}, 32'd0);
      chk("alias_read_data", r, {x_dm, x_cnt[30:0]});
`endif
    end

    @(negedge clk);
    @(negedge clk);
    chk("x_sb_empty", x_exp_q.size(), 32'd0);
    chk("y_sb_empty", y_exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
